// File: rtl/buffer_2l_filler_pkg.sv
// Shared state encoding and word/byte helpers for the two-line buffer filler.
package buffer_2l_filler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PRIME = 2'd2,
    ST_READY = 2'd3
  } state_t;

  function automatic int word_bytes(input int data_bits);
    return data_bits / 8;
  endfunction

endpackage

// File: rtl/buffer_2l_filler.sv
// Write-side controller for a two-line ping-pong buffer: fetches lines over an ack bus.
// Optional build macro FILLER_UNDERRUN_CNT_EN adds a saturating underrun counter port.
//
// state | meaning
// IDLE  | frame finished or not started; waits for frame_start
// FETCH | mem_cs held, one buffer write per mem_ack
// PRIME | line 0 filled; unconditional switch so line 1 can be fetched
// READY | line filled; waits for line_req (or a pending one) to switch
module buffer_2l_filler
  import buffer_2l_filler_pkg::*;
#(
  parameter int DATA_BITS     = 32,
  parameter int ADDR_BITS     = 8,
  parameter int LINE_WORDS    = 256,
  parameter int LINE_COUNT    = 480,
  parameter int MEM_ADDR_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic [MEM_ADDR_BITS-1:0] base_addr,
  input  logic                     line_req,
  output logic                     mem_cs,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  input  logic [DATA_BITS-1:0]     mem_din,
  input  logic                     mem_ack,
  output logic                     buf_switch,
  output logic                     buf_en_w,
  output logic [ADDR_BITS-1:0]     buf_addr_w,
  output logic [DATA_BITS-1:0]     buf_data_w,
  output logic                     line_ready,
  output logic                     underrun
`ifdef FILLER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]              underrun_cnt
`endif
);

  localparam int LC_W = $clog2(LINE_COUNT + 1);
  localparam logic [MEM_ADDR_BITS-1:0] STEP      = MEM_ADDR_BITS'(word_bytes(DATA_BITS));
  localparam logic [ADDR_BITS-1:0]     LAST_WORD = ADDR_BITS'(LINE_WORDS - 1);
  localparam logic [LC_W-1:0]          LAST_LINE = LC_W'(LINE_COUNT);

  state_t                   state;
  logic [ADDR_BITS-1:0]     word_cnt;
  logic [LC_W-1:0]          line_cnt;
  logic                     pending;
  logic [MEM_ADDR_BITS-1:0] addr;

  logic run;
  logic ack_ok;
  logic early;
  logic sw_ready;

  // frame_start and reset both override anything else happening this cycle
  always_comb begin
    run      = rst_n && !frame_start;
    ack_ok   = run && (state == ST_FETCH) && mem_ack;
    early    = run && line_req && ((state == ST_FETCH) || (state == ST_PRIME));
    sw_ready = run && (state == ST_READY) && (line_req || pending);
  end

  assign mem_cs     = rst_n && (state == ST_FETCH);
  assign mem_addr   = addr;
  assign buf_en_w   = ack_ok;
  assign buf_addr_w = ack_ok ? word_cnt : '0;
  assign buf_data_w = ack_ok ? mem_din : '0;
  assign buf_switch = (rst_n && (state == ST_PRIME)) || sw_ready;
  assign line_ready = rst_n && (state == ST_READY);
  assign underrun   = early;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      line_cnt <= '0;
      pending  <= 1'b0;
      addr     <= '0;
    end else if (frame_start) begin
      state    <= ST_FETCH;
      word_cnt <= '0;
      line_cnt <= '0;
      pending  <= 1'b0;
      addr     <= base_addr;
    end else begin
      case (state)
        ST_IDLE: begin
        end
        ST_FETCH: begin
          if (line_req) pending <= 1'b1;
          if (mem_ack) begin
            addr <= addr + STEP;
            if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              line_cnt <= line_cnt + LC_W'(1);
              state    <= (line_cnt == '0) ? ST_PRIME : ST_READY;
            end else begin
              word_cnt <= word_cnt + ADDR_BITS'(1);
            end
          end
        end
        ST_PRIME: begin
          if (line_cnt == LAST_LINE) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
          end else begin
            state <= ST_FETCH;
            if (line_req) pending <= 1'b1;
          end
        end
        ST_READY: begin
          if (line_req || pending) begin
            pending <= 1'b0;
            state   <= (line_cnt == LAST_LINE) ? ST_IDLE : ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FILLER_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || frame_start) begin
      underrun_cnt <= '0;
    end else if (early && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_buffer_2l_filler.sv
// Bench for buffer_2l_filler: vector table for the first frame, scoreboard for buffer writes.
module tb_buffer_2l_filler;

  localparam int LW = 4;
  localparam int LC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_req = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] mem_din = '0;
  logic        mem_cs, buf_switch, buf_en_w, line_ready, underrun;
  logic [31:0] mem_addr, buf_data_w;
  logic [7:0]  buf_addr_w;
`ifdef FILLER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  always #5 clk = ~clk;

  buffer_2l_filler #(
    .DATA_BITS(32), .ADDR_BITS(8), .LINE_WORDS(LW), .LINE_COUNT(LC), .MEM_ADDR_BITS(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .base_addr(base_addr),
    .line_req(line_req), .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .buf_switch(buf_switch), .buf_en_w(buf_en_w),
    .buf_addr_w(buf_addr_w), .buf_data_w(buf_data_w), .line_ready(line_ready),
    .underrun(underrun)
`ifdef FILLER_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  typedef struct {
    logic        fs, lr, ack;
    logic [31:0] ba;
    logic [31:0] cs, maddr, en, waddr, sw, rdy, und;
  } vec_t;

  vec_t        tbl[14];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_maddr = '0;
  logic [7:0]  exp_widx = '0;
  logic        last_take = 1'b0;
  logic [39:0] sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // one clock: drive at negedge, check 1ns later, advance the bench's address model
  task automatic cyc(input logic fs, input logic lr, input logic ack, input logic [31:0] ba);
    logic [39:0] ent;
    @(negedge clk);
    frame_start = fs;
    line_req    = lr;
    base_addr   = ba;
    mem_ack     = ack & mem_cs;
    mem_din     = mem_ack ? mem_word(mem_addr) : 32'h0;
    last_take   = mem_ack & ~fs;
    if (last_take) sb.push_back({exp_widx, mem_word(exp_maddr)});
    #1;
    if (last_take) chk("mem_addr", mem_addr, exp_maddr);
    chk("buf_en_w", 32'(buf_en_w), 32'(last_take));
    if (buf_en_w) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(buf_en_w), 32'h0);
      end else begin
        ent = sb.pop_front();
        chk("buf_addr_w", 32'(buf_addr_w), 32'(ent[39:32]));
        chk("buf_data_w", buf_data_w, ent[31:0]);
      end
    end
    if (fs) begin
      exp_maddr = ba;
      exp_widx  = '0;
    end else if (last_take) begin
      exp_maddr = exp_maddr + 32'd4;
      exp_widx  = (exp_widx == 8'(LW - 1)) ? 8'd0 : exp_widx + 8'd1;
    end
  endtask

  task automatic run_line(input int max_stall);
    int words;
    int budget;
    words  = 0;
    budget = 100;
    while (words < LW && budget > 0) begin
      int st;
      st = $urandom_range(0, max_stall);
      repeat (st) begin
        cyc(0, 0, 0, 0);
        chk("cs_hold", 32'(mem_cs), 32'h1);
        chk("addr_hold", mem_addr, exp_maddr);
        budget--;
      end
      cyc(0, 0, 1, 0);
      if (last_take) words++;
      budget--;
    end
    chk("line_words", 32'(words), 32'(LW));
  endtask

  task automatic serve();
    cyc(0, 1, 0, 0);
    chk("serve_sw", 32'(buf_switch), 32'h1);
    chk("serve_rdy", 32'(line_ready), 32'h1);
    chk("serve_und", 32'(underrun), 32'h0);
  endtask

  initial begin
    //             fs lr ack ba            cs maddr         en waddr sw rdy und
    tbl[0]  = '{0, 1, 0, 32'h0,     0, 32'h0,    0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 32'h1000,  0, 32'h0,    0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 32'h0,     1, 32'h1000, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 32'h0,     1, 32'h1004, 1, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 32'h0,     1, 32'h1008, 1, 2, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 32'h0,     1, 32'h100C, 1, 3, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 32'h0,     0, 32'h1010, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 32'h0,     1, 32'h1010, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 32'h0,     1, 32'h1014, 1, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 1, 32'h0,     1, 32'h1018, 1, 2, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 32'h0,     1, 32'h101C, 1, 3, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 32'h0,     0, 32'h1020, 0, 0, 0, 1, 0};
    tbl[12] = '{0, 1, 0, 32'h0,     0, 32'h1020, 0, 0, 1, 1, 0};
    tbl[13] = '{0, 0, 0, 32'h0,     1, 32'h1020, 0, 0, 0, 0, 0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_cs", 32'(mem_cs), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_rdy", 32'(line_ready), 32'h0);
    chk("rst_sw", 32'(buf_switch), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].fs, tbl[i].lr, tbl[i].ack, tbl[i].ba);
      chk($sformatf("v%0d_cs", i), 32'(mem_cs), tbl[i].cs);
      chk($sformatf("v%0d_maddr", i), mem_addr, tbl[i].maddr);
      chk($sformatf("v%0d_en", i), 32'(buf_en_w), tbl[i].en);
      chk($sformatf("v%0d_waddr", i), 32'(buf_addr_w), tbl[i].waddr);
      chk($sformatf("v%0d_sw", i), 32'(buf_switch), tbl[i].sw);
      chk($sformatf("v%0d_rdy", i), 32'(line_ready), tbl[i].rdy);
      chk($sformatf("v%0d_und", i), 32'(underrun), tbl[i].und);
    end

    // early requests during line 2: two underruns, one switch right after the last word
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    chk("early1_und", 32'(underrun), 32'h1);
    cyc(0, 1, 1, 0);
    chk("early2_und", 32'(underrun), 32'h1);
    chk("early2_sw", 32'(buf_switch), 32'h0);
    cyc(0, 0, 0, 0);
    chk("pend_sw", 32'(buf_switch), 32'h1);
    chk("pend_rdy", 32'(line_ready), 32'h1);
    chk("pend_und", 32'(underrun), 32'h0);
    cyc(0, 0, 0, 0);
    chk("pend_rdy_drop", 32'(line_ready), 32'h0);
    chk("pend_next_cs", 32'(mem_cs), 32'h1);
    chk("pend_next_addr", mem_addr, 32'h1030);

    // line 3: one more early request, then restart the frame after word 2
    cyc(0, 1, 1, 0);
    chk("early3_und", 32'(underrun), 32'h1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
`ifdef FILLER_UNDERRUN_CNT_EN
    chk("ucnt_3", 32'(underrun_cnt), 32'd3);
`endif
    cyc(1, 0, 1, 32'h8000);
    chk("fs_drop_en", 32'(buf_en_w), 32'h0);
    chk("fs_sw", 32'(buf_switch), 32'h0);
    cyc(0, 0, 1, 0);
    chk("fs_addr", mem_addr, 32'h8000);
    chk("fs_waddr", 32'(buf_addr_w), 32'h0);
`ifdef FILLER_UNDERRUN_CNT_EN
    chk("ucnt_clr", 32'(underrun_cnt), 32'd0);
`endif
    repeat (3) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("fs_prime_sw", 32'(buf_switch), 32'h1);

    // rest of the restarted frame with random ack stalls
    run_line(5);
    cyc(0, 0, 0, 0);
    chk("wait_rdy1", 32'(line_ready), 32'h1);
    chk("wait_sw1", 32'(buf_switch), 32'h0);
    cyc(0, 0, 0, 0);
    chk("wait_rdy2", 32'(line_ready), 32'h1);
    chk("wait_sw2", 32'(buf_switch), 32'h0);
    serve();
    cyc(0, 0, 0, 0);
    chk("lat_cs", 32'(mem_cs), 32'h1);
    chk("lat_addr", mem_addr, 32'h8020);
    run_line(5);
    serve();
    run_line(5);
    serve();
    cyc(0, 0, 0, 0);
    chk("end_cs", 32'(mem_cs), 32'h0);
    chk("end_rdy", 32'(line_ready), 32'h0);
    cyc(0, 1, 0, 0);
    chk("idle_und", 32'(underrun), 32'h0);
    chk("idle_sw", 32'(buf_switch), 32'h0);
    repeat (3) cyc(0, 0, 1, 0);
    chk("idle_cs", 32'(mem_cs), 32'h0);

    // address wrap, then reset in the middle of a burst
    cyc(1, 0, 0, 32'hFFFF_FFF8);
    repeat (4) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("wrap_prime_sw", 32'(buf_switch), 32'h1);
    cyc(0, 0, 0, 0);
    chk("wrap_addr", mem_addr, 32'h0000_0008);
    @(negedge clk);
    rst_n    = 1'b0;
    line_req = 1'b1;
    mem_ack  = 1'b1;
    mem_din  = 32'hCAFE_F00D;
    #1;
    chk("rstmid_cs", 32'(mem_cs), 32'h0);
    chk("rstmid_en", 32'(buf_en_w), 32'h0);
    chk("rstmid_und", 32'(underrun), 32'h0);
    exp_maddr = '0;
    exp_widx  = '0;
    @(negedge clk);
    rst_n    = 1'b1;
    line_req = 1'b0;
    mem_ack  = 1'b0;
    #1;
    chk("rstmid_after_cs", 32'(mem_cs), 32'h0);
    chk("rstmid_after_addr", mem_addr, 32'h0);
    cyc(0, 1, 0, 0);
    chk("rstmid_idle_und", 32'(underrun), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
